// File: rtl/sorter_pkg.sv
// Shared types for the 16-input bitonic sorter and its top-K drain stage.
package sorter_pkg;

    localparam int SORT_DW = 8;
    localparam int SORT_N  = 16;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [3:0] stage;
    } ctrl_t;

    typedef struct packed {
        logic [SORT_N-1:0][SORT_DW-1:0]   data_16;
        logic [SORT_N/2-1:0][SORT_DW-1:0] data_8;
    } data_o_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    // Rank index width; a single-element frame still needs one bit.
    function automatic int drain_idx_width(input int k);
        int w;
        w = $clog2(k);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sorter_frame_buf.sv
// Two-slot frame store: one K-element frame written per slot, one element read.
module sorter_frame_buf
    import sorter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int K         = 4,
    parameter int IW        = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we,
    input  logic                          wptr,
    input  logic [K-1:0][DATAWIDTH-1:0]   frame,
    input  logic                          rptr,
    input  logic [IW-1:0]                 elem,
    output logic [DATAWIDTH-1:0]          rdata
);

    logic [1:0][K-1:0][DATAWIDTH-1:0] mem_r;

    // Slot write; the slot being read is never the write target while it is live.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[wptr] <= frame;
        end
    end

    assign rdata = mem_r[rptr][elem];

endmodule

// File: rtl/sorter_topk_drain.sv
// Streams the first K elements of each sorted frame over valid/ready,
// buffering up to two frames and dropping (with a sticky flag) beyond that.
module sorter_topk_drain
    import sorter_pkg::*;
#(
    parameter int  DATAWIDTH  = 8,
    parameter int  DATALENGTH = 16,
    parameter int  K          = 4,
    localparam int IW         = drain_idx_width(K)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ctrl_t                 ctrl_i,
    input  data_o_t               y_i,
    input  logic                  clr_i,
    output logic [DATAWIDTH-1:0]  data_o,
    output logic [IW-1:0]         idx_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i,
    output logic                  overflow_o,
    output logic [1:0]            occ_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    drain_state_e                 state_r;
    logic                         wr_ptr_r;
    logic                         rd_ptr_r;
    logic [IW-1:0]                elem_r;
    logic [1:0]                   occ_r;
    logic                         ovf_r;
    logic                         last_r;

    logic                         hs_s;
    logic                         final_s;
    logic                         capture_s;
    logic                         drop_s;
    logic [1:0]                   occ_next_s;
    logic [IW-1:0]                elem_next_s;
    logic [K-1:0][DATAWIDTH-1:0]  frame_s;
    logic [DATAWIDTH-1:0]         rdata_s;
    logic                         unused_s;

    assign unused_s = ^{ctrl_i, y_i, DATALENGTH};

    // Only the top K ranks of the sorted result are kept.
    always_comb begin
        frame_s = '0;
        for (int i = 0; i < K; i++) begin
            frame_s[i] = DATAWIDTH'(y_i.data_16[i]);
        end
    end

    assign hs_s      = (state_r == STREAM) && ready_i;
    assign final_s   = hs_s && (elem_r == LAST_IDX);
    // A full buffer still accepts when its oldest frame retires this cycle.
    assign capture_s = ctrl_i.valid && ((occ_r != 2'd2) || final_s);
    assign drop_s    = ctrl_i.valid && !capture_s;

    // Occupancy after this edge's capture and retirement.
    always_comb begin
        occ_next_s = occ_r;
        case ({capture_s, final_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // Element rank advance on each accepted beat.
    always_comb begin
        elem_next_s = elem_r;
        if (final_s) begin
            elem_next_s = '0;
        end else if (hs_s) begin
            elem_next_s = elem_r + IW'(1'b1);
        end else begin
            elem_next_s = elem_r;
        end
    end

    // Read FSM with registered rank and last flag; looks at next occupancy so no bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            elem_r  <= '0;
            last_r  <= 1'b0;
        end else begin
            elem_r <= elem_next_s;
            last_r <= (occ_next_s != 2'd0) && (elem_next_s == LAST_IDX);
            case (state_r)
                IDLE:    state_r <= (occ_next_s != 2'd0) ? STREAM : IDLE;
                STREAM:  state_r <= (occ_next_s != 2'd0) ? STREAM : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Ping-pong pointers and frame count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            occ_r <= occ_next_s;
            if (capture_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (final_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Sticky drop flag; a drop outranks a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clr_i) begin
            ovf_r <= 1'b0;
        end
    end

    sorter_frame_buf #(
        .DATAWIDTH (DATAWIDTH),
        .K         (K),
        .IW        (IW)
    ) u_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (capture_s),
        .wptr  (wr_ptr_r),
        .frame (frame_s),
        .rptr  (rd_ptr_r),
        .elem  (elem_r),
        .rdata (rdata_s)
    );

    assign data_o     = rdata_s;
    assign idx_o      = elem_r;
    assign valid_o    = (state_r == STREAM);
    assign last_o     = last_r;
    assign overflow_o = ovf_r;
    assign occ_o      = occ_r;

endmodule
